// File: rtl/axi_id_remap_pkg.sv
// Shared types for the AXI ID remapper: the per-entry record of one remap table
// and the width of its outstanding-transaction counter.
package axi_id_remap_pkg;
    localparam int ID_IN_W  = 12;
    localparam int MAX_TXNS = 4;
    localparam int CNT_W    = $clog2(MAX_TXNS + 1);

    typedef struct packed {
        logic               valid;
        logic [ID_IN_W-1:0] orig_id;
        logic [CNT_W-1:0]   cnt;
    } entry_t;
endpackage

// File: rtl/axi_id_remap_if.sv
// AXI4 bus bundle with a parameterised ID width; Master drives requests, Slave answers.
interface AXI_BUS #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1
);
    typedef logic [AXI_ID_WIDTH-1:0]   id_t;
    typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
    typedef logic [AXI_DATA_WIDTH-1:0] data_t;
    typedef logic [AXI_USER_WIDTH-1:0] user_t;

    id_t aw_id;   addr_t aw_addr; logic [7:0] aw_len; logic [2:0] aw_size; logic [1:0] aw_burst;
    logic aw_lock; logic [3:0] aw_cache; logic [2:0] aw_prot; logic [3:0] aw_qos; user_t aw_user;
    logic aw_valid, aw_ready;
    data_t w_data; logic [AXI_DATA_WIDTH/8-1:0] w_strb; logic w_last; user_t w_user;
    logic w_valid, w_ready;
    id_t b_id; logic [1:0] b_resp; user_t b_user; logic b_valid, b_ready;
    id_t ar_id;   addr_t ar_addr; logic [7:0] ar_len; logic [2:0] ar_size; logic [1:0] ar_burst;
    logic ar_lock; logic [3:0] ar_cache; logic [2:0] ar_prot; logic [3:0] ar_qos; user_t ar_user;
    logic ar_valid, ar_ready;
    id_t r_id; data_t r_data; logic [1:0] r_resp; logic r_last; user_t r_user;
    logic r_valid, r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_id_remap_table.sv
// One direction's ID remap table: lookup/allocation of an output ID per request,
// lock of the issued ID while the request waits, and orig-ID restore on responses.
module axi_id_remap_table import axi_id_remap_pkg::*; #(
    parameter int ID_OUT_W        = 4,
    parameter int MAX_TXNS_PER_ID = MAX_TXNS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ID_IN_W-1:0]  req_id,
    output logic                fwd_valid,
    input  logic                fwd_ready,
    output logic [ID_OUT_W-1:0] fwd_id,
    input  logic                rsp_valid,
    input  logic                rsp_pop,
    input  logic [ID_OUT_W-1:0] rsp_id,
    output logic [ID_IN_W-1:0]  rsp_orig_id
);
    localparam int DEPTH = 2**ID_OUT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TXNS_PER_ID);

    entry_t [DEPTH-1:0]  tbl;
    logic                match_hit, free_hit, stall, push, lock_vld;
    logic [ID_OUT_W-1:0] match_idx, free_idx, lock_idx, sel_idx;
    logic [DEPTH-1:0]    psh, pop;

    // Descending scan so the lowest index wins both searches.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (tbl[i].valid && tbl[i].orig_id == req_id) begin
                match_hit = 1'b1;
                match_idx = ID_OUT_W'(i);
            end
            if (!tbl[i].valid) begin
                free_hit = 1'b1;
                free_idx = ID_OUT_W'(i);
            end
        end
    end

    // A locked index never becomes full: its count can only drop until the handshake.
    assign sel_idx   = lock_vld ? lock_idx : (match_hit ? match_idx : free_idx);
    assign stall     = !lock_vld && (match_hit ? (tbl[match_idx].cnt == CNT_MAX) : !free_hit);
    assign fwd_valid = req_valid && !stall;
    assign req_ready = fwd_ready && !stall;
    assign fwd_id    = sel_idx;
    assign push      = fwd_valid && fwd_ready;

    always_comb begin
        psh = '0;
        pop = '0;
        for (int i = 0; i < DEPTH; i++) begin
            psh[i] = push && (sel_idx == ID_OUT_W'(i));
            pop[i] = rsp_pop && (rsp_id == ID_OUT_W'(i)) && tbl[i].valid;
        end
    end

    assign rsp_orig_id = tbl[rsp_id].valid ? tbl[rsp_id].orig_id : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl      <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
        end else begin
            lock_vld <= fwd_valid && !fwd_ready;
            lock_idx <= sel_idx;
            for (int i = 0; i < DEPTH; i++) begin
                if (psh[i] && !pop[i]) begin
                    tbl[i].valid   <= 1'b1;
                    tbl[i].orig_id <= req_id;
                    tbl[i].cnt     <= tbl[i].cnt + 1'b1;
                end else if (!psh[i] && pop[i]) begin
                    tbl[i].cnt <= tbl[i].cnt - 1'b1;
                    if (tbl[i].cnt == CNT_W'(1)) tbl[i].valid <= 1'b0;
                end
            end
        end
    end

    // A response for an ID with nothing outstanding is an upstream protocol error.
    assert property (@(posedge clk) disable iff (!rst_n) rsp_valid |-> tbl[rsp_id].valid);
endmodule

// File: rtl/axi_id_remap.sv
// Compresses wide crossbar IDs into a 2**AXI_ID_OUT_WIDTH ID space, one remap table
// per direction; all non-ID payload passes straight through.
module axi_id_remap import axi_id_remap_pkg::*; #(
    parameter int AXI_ID_IN_WIDTH  = ID_IN_W,
    parameter int AXI_ID_OUT_WIDTH = 4,
    parameter int MAX_TXNS_PER_ID  = MAX_TXNS
) (
    input  logic   clk,
    input  logic   rst_n,
    AXI_BUS.Slave  slave,
    AXI_BUS.Master master
);
    // Entry storage is sized by the package; reject overrides it cannot hold.
    if (AXI_ID_IN_WIDTH != ID_IN_W || MAX_TXNS_PER_ID >= 2**CNT_W) begin : g_param_err
        $error("axi_id_remap: ID width or per-ID depth exceeds entry storage");
    end

    axi_id_remap_table #(.ID_OUT_W(AXI_ID_OUT_WIDTH), .MAX_TXNS_PER_ID(MAX_TXNS_PER_ID)) u_wr (
        .clk, .rst_n,
        .req_valid(slave.aw_valid), .req_ready(slave.aw_ready), .req_id(slave.aw_id),
        .fwd_valid(master.aw_valid), .fwd_ready(master.aw_ready), .fwd_id(master.aw_id),
        .rsp_valid(master.b_valid), .rsp_pop(master.b_valid && slave.b_ready),
        .rsp_id(master.b_id), .rsp_orig_id(slave.b_id)
    );

    axi_id_remap_table #(.ID_OUT_W(AXI_ID_OUT_WIDTH), .MAX_TXNS_PER_ID(MAX_TXNS_PER_ID)) u_rd (
        .clk, .rst_n,
        .req_valid(slave.ar_valid), .req_ready(slave.ar_ready), .req_id(slave.ar_id),
        .fwd_valid(master.ar_valid), .fwd_ready(master.ar_ready), .fwd_id(master.ar_id),
        .rsp_valid(master.r_valid), .rsp_pop(master.r_valid && slave.r_ready && master.r_last),
        .rsp_id(master.r_id), .rsp_orig_id(slave.r_id)
    );

    assign master.aw_addr  = slave.aw_addr;
    assign master.aw_len   = slave.aw_len;
    assign master.aw_size  = slave.aw_size;
    assign master.aw_burst = slave.aw_burst;
    assign master.aw_lock  = slave.aw_lock;
    assign master.aw_cache = slave.aw_cache;
    assign master.aw_prot  = slave.aw_prot;
    assign master.aw_qos   = slave.aw_qos;
    assign master.aw_user  = slave.aw_user;

    assign master.w_data   = slave.w_data;
    assign master.w_strb   = slave.w_strb;
    assign master.w_last   = slave.w_last;
    assign master.w_user   = slave.w_user;
    assign master.w_valid  = slave.w_valid;
    assign slave.w_ready   = master.w_ready;

    assign slave.b_resp    = master.b_resp;
    assign slave.b_user    = master.b_user;
    assign slave.b_valid   = master.b_valid;
    assign master.b_ready  = slave.b_ready;

    assign master.ar_addr  = slave.ar_addr;
    assign master.ar_len   = slave.ar_len;
    assign master.ar_size  = slave.ar_size;
    assign master.ar_burst = slave.ar_burst;
    assign master.ar_lock  = slave.ar_lock;
    assign master.ar_cache = slave.ar_cache;
    assign master.ar_prot  = slave.ar_prot;
    assign master.ar_qos   = slave.ar_qos;
    assign master.ar_user  = slave.ar_user;

    assign slave.r_data    = master.r_data;
    assign slave.r_resp    = master.r_resp;
    assign slave.r_last    = master.r_last;
    assign slave.r_user    = master.r_user;
    assign slave.r_valid   = master.r_valid;
    assign master.r_ready  = slave.r_ready;
endmodule

// File: tb/tb_axi_id_remap.sv
// Directed bench for axi_id_remap: allocation, per-ID depth stall, table-full stall,
// ID lock, same-cycle push/pop and asynchronous reset.
module tb_axi_id_remap;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    AXI_BUS #(.AXI_ID_WIDTH(12)) s ();
    AXI_BUS #(.AXI_ID_WIDTH(4))  m ();

    axi_id_remap #(.AXI_ID_IN_WIDTH(12), .AXI_ID_OUT_WIDTH(4), .MAX_TXNS_PER_ID(4)) dut (
        .clk(clk), .rst_n(rst_n), .slave(s.Slave), .master(m.Master)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic aw_req(input logic [11:0] id, input logic [3:0] exp);
        @(negedge clk);
        s.aw_valid = 1'b1; s.aw_id = id; m.aw_ready = 1'b1;
        #1;
        chk("aw_id", 32'(m.aw_id), 32'(exp));
        chk("aw_ready", 32'(s.aw_ready), 32'd1);
        @(posedge clk); #1;
        s.aw_valid = 1'b0;
    endtask

    task automatic ar_req(input logic [11:0] id, input logic [3:0] exp);
        @(negedge clk);
        s.ar_valid = 1'b1; s.ar_id = id; m.ar_ready = 1'b1;
        #1;
        chk("ar_id", 32'(m.ar_id), 32'(exp));
        @(posedge clk); #1;
        s.ar_valid = 1'b0;
    endtask

    task automatic b_rsp(input logic [3:0] id, input logic [11:0] exp);
        @(negedge clk);
        m.b_valid = 1'b1; m.b_id = id; s.b_ready = 1'b1;
        #1;
        chk("b_id", 32'(s.b_id), 32'(exp));
        @(posedge clk); #1;
        m.b_valid = 1'b0;
    endtask

    task automatic r_rsp(input logic [3:0] id, input logic last, input logic [11:0] exp);
        @(negedge clk);
        m.r_valid = 1'b1; m.r_id = id; m.r_last = last; s.r_ready = 1'b1;
        #1;
        chk("r_id", 32'(s.r_id), 32'(exp));
        @(posedge clk); #1;
        m.r_valid = 1'b0; m.r_last = 1'b0;
    endtask

    initial begin
        s.aw_id = '0; s.aw_addr = '0; s.aw_len = '0; s.aw_size = '0; s.aw_burst = '0; s.aw_lock = 1'b0;
        s.aw_cache = '0; s.aw_prot = '0; s.aw_qos = '0; s.aw_user = '0; s.aw_valid = 1'b0;
        s.w_data = '0; s.w_strb = '0; s.w_last = 1'b0; s.w_user = '0; s.w_valid = 1'b0; s.b_ready = 1'b0;
        s.ar_id = '0; s.ar_addr = '0; s.ar_len = '0; s.ar_size = '0; s.ar_burst = '0; s.ar_lock = 1'b0;
        s.ar_cache = '0; s.ar_prot = '0; s.ar_qos = '0; s.ar_user = '0; s.ar_valid = 1'b0; s.r_ready = 1'b0;
        m.aw_ready = 1'b0; m.w_ready = 1'b0; m.ar_ready = 1'b0;
        m.b_id = '0; m.b_resp = '0; m.b_user = '0; m.b_valid = 1'b0;
        m.r_id = '0; m.r_data = '0; m.r_resp = '0; m.r_last = 1'b0; m.r_user = '0; m.r_valid = 1'b0;

        // Reset state
        #12;
        chk("rst_aw_valid", 32'(m.aw_valid), 32'd0);
        chk("rst_ar_valid", 32'(m.ar_valid), 32'd0);
        chk("rst_aw_id", 32'(m.aw_id), 32'd0);
        chk("rst_ar_id", 32'(m.ar_id), 32'd0);
        s.w_data = 32'hDEADBEEF;
        #1;
        chk("w_data", m.w_data, 32'hDEADBEEF);
        @(negedge clk); rst_n = 1'b1;

        // Basic allocate / restore / free
        aw_req(12'h123, 4'd0);
        b_rsp(4'd0, 12'h123);
        aw_req(12'h456, 4'd0);
        b_rsp(4'd0, 12'h456);

        // Per-ID depth: fifth same-ID AW stalls until a B retires
        for (int i = 0; i < 4; i++) aw_req(12'h010, 4'd0);
        @(negedge clk);
        s.aw_valid = 1'b1; s.aw_id = 12'h010; m.aw_ready = 1'b1;
        m.b_valid = 1'b1; m.b_id = 4'd0; s.b_ready = 1'b1;
        #1;
        chk("depth_stall_ready", 32'(s.aw_ready), 32'd0);
        chk("depth_stall_valid", 32'(m.aw_valid), 32'd0);
        chk("depth_b_id", 32'(s.b_id), 32'h010);
        @(posedge clk); #1;
        m.b_valid = 1'b0;
        #1;
        chk("depth_resume_ready", 32'(s.aw_ready), 32'd1);
        chk("depth_resume_id", 32'(m.aw_id), 32'd0);
        @(posedge clk); #1;
        s.aw_valid = 1'b0;
        for (int i = 0; i < 4; i++) b_rsp(4'd0, 12'h010);

        // Read table full: 17th distinct ID waits for an R with r_last
        for (int i = 0; i < 16; i++) ar_req(12'h100 + 12'(i), 4'(i));
        @(negedge clk);
        s.ar_valid = 1'b1; s.ar_id = 12'h200; m.ar_ready = 1'b1;
        m.r_valid = 1'b1; m.r_id = 4'd5; m.r_last = 1'b0; s.r_ready = 1'b1;
        #1;
        chk("full_stall_ready", 32'(s.ar_ready), 32'd0);
        chk("full_stall_valid", 32'(m.ar_valid), 32'd0);
        chk("full_r_id", 32'(s.r_id), 32'h105);
        @(posedge clk); #1;
        chk("nolast_still_stall", 32'(s.ar_ready), 32'd0);
        m.r_last = 1'b1;
        @(posedge clk); #1;
        m.r_valid = 1'b0; m.r_last = 1'b0;
        #1;
        chk("full_resume_ready", 32'(s.ar_ready), 32'd1);
        chk("full_resume_id", 32'(m.ar_id), 32'd5);
        @(posedge clk); #1;
        s.ar_valid = 1'b0;
        for (int i = 0; i < 16; i++) r_rsp(4'(i), 1'b1, (i == 5) ? 12'h200 : 12'h100 + 12'(i));

        // Lock: held AW on out-ID 3 keeps its ID while entry 1 frees
        aw_req(12'h0A0, 4'd0);
        aw_req(12'h0A1, 4'd1);
        aw_req(12'h0A2, 4'd2);
        @(negedge clk);
        s.aw_valid = 1'b1; s.aw_id = 12'h0A3; m.aw_ready = 1'b0;
        m.b_valid = 1'b1; m.b_id = 4'd1; s.b_ready = 1'b1;
        #1;
        chk("lock_first_id", 32'(m.aw_id), 32'd3);
        chk("lock_wait_ready", 32'(s.aw_ready), 32'd0);
        chk("lock_b_id", 32'(s.b_id), 32'h0A1);
        @(posedge clk); #1;
        m.b_valid = 1'b0;
        #1;
        chk("lock_hold_id", 32'(m.aw_id), 32'd3);
        @(negedge clk);
        m.aw_ready = 1'b1;
        #1;
        chk("lock_release_id", 32'(m.aw_id), 32'd3);
        @(posedge clk); #1;
        s.aw_valid = 1'b0;
        aw_req(12'h0B0, 4'd1);

        // Same-cycle push and retire on entry 2 (cnt 1)
        @(negedge clk);
        s.aw_valid = 1'b1; s.aw_id = 12'h0A2; m.aw_ready = 1'b1;
        m.b_valid = 1'b1; m.b_id = 4'd2; s.b_ready = 1'b1;
        #1;
        chk("same_aw_id", 32'(m.aw_id), 32'd2);
        chk("same_b_id", 32'(s.b_id), 32'h0A2);
        @(posedge clk); #1;
        s.aw_valid = 1'b0; m.b_valid = 1'b0;
        aw_req(12'h0D0, 4'd4);
        b_rsp(4'd2, 12'h0A2);
        aw_req(12'h0C0, 4'd2);

        // Asynchronous reset with five writes outstanding
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        s.aw_valid = 1'b1; s.aw_id = 12'h7FF; m.aw_ready = 1'b0; m.b_id = 4'd3;
        #1;
        chk("arst_aw_id", 32'(m.aw_id), 32'd0);
        chk("arst_b_id", 32'(s.b_id), 32'd0);
        s.aw_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        aw_req(12'h7FF, 4'd0);
        b_rsp(4'd0, 12'h7FF);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_id_remap.md
# axi_id_remap

Downstream companion to the sliced AXI crossbar: compresses the widened IDs on a crossbar master port (slave ID width plus clog2 of the slave count) to a small ID space that narrow-ID peripherals and memory controllers accept. Each direction has a remap table. An incoming ID is mapped to a free or already-matching output ID. The original ID is restored on B/R responses. Channel data passes through combinationally; only ID fields and the AW/AR valid/ready pairs are altered.

## Interface
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 32, data width
- AXI_USER_WIDTH, 1, user width
- AXI_ID_IN_WIDTH, 12, ID width on slave side
- AXI_ID_OUT_WIDTH, 4, ID width on master side; table depth is 2**AXI_ID_OUT_WIDTH
- MAX_TXNS_PER_ID, 4, outstanding transactions per table entry
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- slave  AXI_BUS.Slave  (ID = AXI_ID_IN_WIDTH)  from crossbar master port
- master  AXI_BUS.Master  (ID = AXI_ID_OUT_WIDTH)  to downstream slave

## Operation
- Entry state: valid, orig_id[AXI_ID_IN_WIDTH], cnt[clog2(MAX_TXNS_PER_ID+1)].
- There is one table for the write direction (AW/B) and one for the read direction (AR/R).
- Request lookup for AW and AR, in priority order:
  - A valid entry with orig_id == request ID and cnt < MAX gives that index.
  - A matching entry with cnt == MAX stalls the request. No second entry is allocated, so same-ID ordering is preserved.
  - With no match, the lowest-index invalid entry is used.
  - With no match and the table full, the request stalls.
- Stall means master.*_valid = 0 and slave.*_ready = 0. Otherwise master.*_valid = slave.*_valid, slave.*_ready = master.*_ready, and master ID = the chosen index.
- Lock:
  - Set when master.aw_valid && !aw_ready. It stores the chosen index and holds it until the handshake, so the outgoing ID cannot change while valid.
  - Cleared on the handshake.
  - AR has an identical lock.
- Request handshake: the entry becomes valid with orig_id = request ID, and cnt increments.
- Responses:
  - B: slave.b_id = orig_id of entry[master.b_id], and cnt decrements on the B handshake.
  - R: slave.r_id is restored the same way, and cnt decrements only on the R handshake with r_last.
  - An entry whose cnt reaches 0 becomes invalid.
  - Response valid/ready pass through unmodified.
- Same-cycle request handshake and response retire on the same entry: cnt is unchanged and the entry stays valid.
- W channel is straight pass-through.
- A response whose ID maps to an invalid entry is a protocol error. It is flagged by an assertion only; data is forwarded with orig_id 0.

## Timing
- Zero-cycle latency on all channels; pure combinational path through ID muxes.
- Table and lock update on the rising clk edge after a handshake.
- A freed entry is allocatable in the next cycle.
- Reset, asynchronous on rst_n low:
  - All entries invalid, cnt 0, locks clear.
  - Outputs are combinational from inputs. Master valids are 0 when slave valids are 0. Master IDs read 0 while the table is empty.
- Reset mid-transaction drops all tracking. Upstream and downstream must be reset together.

## Structure
- Package axi_id_remap_pkg: the entry struct and a clog2-derived counter-width constant.
- Sub-module axi_id_remap_table holds one direction's table:
  - lookup and allocation (lowest-free priority encoder)
  - lock register
  - push/pop counter update
- axi_id_remap instantiates axi_id_remap_table twice (write, read) and wires the AXI_BUS fields.

## Test plan
- Reset, then AW id 0x123 → master aw_id 0; B id 0 → slave b_id 0x123; entry 0 freed (next AW id 0x456 also gets 0).
- Four AWs id 0x010 with MAX=4 → all use out-ID 0, cnt=4; a fifth AW id 0x010 stalls (aw_ready 0) until one B returns, then issues with ID 0.
- 16 distinct AR IDs outstanding → out IDs 0..15; a 17th distinct ID stalls until an R with r_last frees an entry, then takes that freed index. An R beat without r_last frees nothing.
- AW held with aw_ready=0 on out-ID 3 while entry 1 frees → aw_id stays 3 until the handshake.
- Same-cycle AW handshake and B retire on entry 2 with cnt=1 → cnt stays 1 and the entry stays valid.
- Assert rst_n low with 5 transactions outstanding → table empties asynchronously; after release, first AW id 0x7FF gets out-ID 0.
